// File: rtl/dpa_div_pkg.sv
// Shared types and default constants for the DPA post-divider sequencing controller.
package dpa_div_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOLD      = 3'd1,
        WAIT_LOCK = 3'd2,
        DONE      = 3'd3,
        ERR       = 3'd4
    } dpa_div_state_t;

    localparam int DPA_DIV_W      = 4;
    localparam int DPA_DIV_INIT   = 1;
    localparam int DPA_RESET_HOLD = 4;
    localparam int DPA_LOCK_EDGES = 2;
    localparam int DPA_TIMEOUT    = 64;

endpackage

// File: rtl/dpa_div_edge_det.sv
// Two-flop synchronizer for the divided clock feedback plus a registered rising-edge pulse.
module dpa_div_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rise_q, rise_d;

    // Next-state for the synchronizer chain and edge pulse.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        rise_d  = sync1_q & ~sync2_q;
    end

    // Synchronizer and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/dpa_div_ctrl.sv
// Sequencing controller for the DPA post-divider: hold in reset, load modulus,
// release, and confirm the divided clock toggles before reporting lock.
module dpa_div_ctrl
    import dpa_div_pkg::*;
#(
    parameter int DIV_W      = DPA_DIV_W,
    parameter int DIV_INIT   = DPA_DIV_INIT,
    parameter int RESET_HOLD = DPA_RESET_HOLD,
    parameter int LOCK_EDGES = DPA_LOCK_EDGES,
    parameter int TIMEOUT    = DPA_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [DIV_W-1:0] req_div,
    output logic             req_ready,
    output logic             div_reset,
    output logic [DIV_W-1:0] div_value,
    input  logic             div_cout,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             lock_err
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int EDGE_W = $clog2(LOCK_EDGES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [EDGE_W-1:0] EDGE_LOCK = EDGE_W'(LOCK_EDGES);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [DIV_W-1:0]  DIV_RST   = (DIV_INIT == 0) ? DIV_W'(1) : DIV_W'(DIV_INIT);

    dpa_div_state_t    state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [DIV_W-1:0]  div_value_q, div_value_d;
    logic              div_reset_q, div_reset_d;
    logic              req_ready_q, req_ready_d;
    logic              busy_q, busy_d;
    logic              locked_q, locked_d;
    logic              done_q, done_d;
    logic              lock_err_q, lock_err_d;
    logic              cout_rise;

    dpa_div_edge_det u_edge_det (
        .clk      (clk),
        .reset    (reset),
        .async_in (div_cout),
        .rise     (cout_rise)
    );

    // Next-state, counter and output decode.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        div_value_d = div_value_q;
        locked_d    = locked_q;
        lock_err_d  = lock_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = HOLD;
                    hold_cnt_d  = '0;
                    div_value_d = (req_div == '0) ? DIV_W'(1) : req_div;
                    locked_d    = 1'b0;
                    lock_err_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = WAIT_LOCK;
                    edge_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock is tested first so a final edge coinciding with the timeout still wins.
                if (edge_cnt_q == EDGE_LOCK) begin
                    state_d  = DONE;
                    locked_d = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d    = ERR;
                    lock_err_d = 1'b1;
                end else begin
                    edge_cnt_d = edge_cnt_q + EDGE_W'(cout_rise);
                    tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
        endcase

        // Outputs follow the next state so the registered copies line up with state_q.
        div_reset_d = (state_d == HOLD);
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            div_value_q <= DIV_RST;
            div_reset_q <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            div_value_q <= div_value_d;
            div_reset_q <= div_reset_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
            lock_err_q  <= lock_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign div_reset = div_reset_q;
    assign div_value = div_value_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign done      = done_q;
    assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_dpa_div_ctrl.sv
// Self-checking bench for dpa_div_ctrl: timestamp-based reference model checked every
// cycle, a table of request vectors, directed corner sequences and random stimulus.
module tb_dpa_div_ctrl;

    localparam int RESET_HOLD = 4;
    localparam int LOCK_EDGES = 2;
    localparam int TIMEOUT    = 64;

    localparam int P_IDLE = 0;
    localparam int P_HOLD = 1;
    localparam int P_WAIT = 2;
    localparam int P_DONE = 3;
    localparam int P_ERR  = 4;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_div;
    logic       req_ready;
    logic       div_reset;
    logic [3:0] div_value;
    logic       div_cout;
    logic       busy;
    logic       locked;
    logic       done;
    logic       lock_err;

    dpa_div_ctrl #(
        .DIV_W      (4),
        .DIV_INIT   (1),
        .RESET_HOLD (RESET_HOLD),
        .LOCK_EDGES (LOCK_EDGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ready (req_ready),
        .div_reset (div_reset),
        .div_value (div_value),
        .div_cout  (div_cout),
        .busy      (busy),
        .locked    (locked),
        .done      (done),
        .lock_err  (lock_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase plus timestamps of when each phase began.
    int         n_edge = 0;
    int         m_ph = P_HOLD;
    int         m_start = 0;
    int         m_ecnt = 0;
    logic       m_locked = 1'b0;
    logic       m_err = 1'b0;
    logic [3:0] m_val = 4'd1;
    logic       m_prev = 1'b0;
    logic       m_acc = 1'b0;
    int         rise_q[$];

    // divided-clock stimulus: 0 = held low, -1 = random, N = toggle every N cycles
    int cmode = 3;
    int ccnt = 0;
    int rst_hi_cnt = 0;
    int done_cnt = 0;
    int ready_cnt = 0;

    typedef struct {
        logic [3:0] req_div;
        int         cout_per;
        logic [3:0] exp_div;
        logic       exp_locked;
        logic       exp_err;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [3:0] fixd(input logic [3:0] d);
        return (d == 4'd0) ? 4'd1 : d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [3:0] d, input logic c);
        bit cnt_now;
        cnt_now = 1'b0;
        m_acc   = 1'b0;
        n_edge++;
        if (r) begin
            m_ph     = P_HOLD;
            m_start  = n_edge;
            m_val    = 4'd1;
            m_locked = 1'b0;
            m_err    = 1'b0;
            m_prev   = 1'b0;
            rise_q.delete();
        end else begin
            while (rise_q.size() > 0 && rise_q[0] < n_edge) void'(rise_q.pop_front());
            if (rise_q.size() > 0 && rise_q[0] == n_edge) begin
                void'(rise_q.pop_front());
                cnt_now = 1'b1;
            end
            // a rise sampled now is counted two edges later
            if (c && !m_prev) rise_q.push_back(n_edge + 2);
            m_prev = c;
            case (m_ph)
                P_IDLE: if (v) begin
                    m_acc = 1'b1; m_val = fixd(d); m_locked = 1'b0; m_err = 1'b0;
                    m_ph = P_HOLD; m_start = n_edge;
                end
                P_HOLD: if (n_edge - m_start == RESET_HOLD) begin
                    m_ph = P_WAIT; m_start = n_edge; m_ecnt = 0;
                end
                P_WAIT: begin
                    if (m_ecnt >= LOCK_EDGES) begin
                        m_ph = P_DONE; m_locked = 1'b1;
                    end else if (n_edge - m_start == TIMEOUT) begin
                        m_ph = P_ERR; m_err = 1'b1;
                    end else if (cnt_now) begin
                        m_ecnt++;
                    end
                end
                default: m_ph = P_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(reset, req_valid, req_div, div_cout);
        @(negedge clk);
        if (div_reset) rst_hi_cnt++;
        if (done) done_cnt++;
        if (req_ready) ready_cnt++;
        chk($sformatf("cycle%0d_outputs", n_edge),
            {22'd0, div_reset, req_ready, busy, locked, done, lock_err, div_value},
            {22'd0, m_ph == P_HOLD, m_ph == P_IDLE, m_ph != P_IDLE, m_locked,
             m_ph == P_DONE, m_err, m_val});
        if (cmode == 0) begin
            div_cout = 1'b0;
        end else if (cmode < 0) begin
            div_cout = 1'($urandom_range(0, 1));
        end else begin
            ccnt++;
            if (ccnt >= cmode) begin
                ccnt = 0;
                div_cout = ~div_cout;
            end
        end
    endtask

    task automatic run_until_idle(input int budget, input string nm);
        int k;
        k = 0;
        while (m_ph != P_IDLE && k < budget) begin
            tick();
            k++;
        end
        checks++;
        if (m_ph != P_IDLE) begin
            errors++;
            $display("FAIL %s: no return to idle within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        int k;
        clk = 1'b0; reset = 1'b1; req_valid = 1'b0; req_div = 4'd0; div_cout = 1'b0;

        vecs[0] = '{req_div: 4'd5,  cout_per: 3, exp_div: 4'd5,  exp_locked: 1'b1, exp_err: 1'b0};
        vecs[1] = '{req_div: 4'd0,  cout_per: 2, exp_div: 4'd1,  exp_locked: 1'b1, exp_err: 1'b0};
        vecs[2] = '{req_div: 4'd15, cout_per: 1, exp_div: 4'd15, exp_locked: 1'b1, exp_err: 1'b0};
        vecs[3] = '{req_div: 4'd4,  cout_per: 0, exp_div: 4'd4,  exp_locked: 1'b0, exp_err: 1'b1};
        vecs[4] = '{req_div: 4'd4,  cout_per: 4, exp_div: 4'd4,  exp_locked: 1'b1, exp_err: 1'b0};
        vecs[5] = '{req_div: 4'd1,  cout_per: 5, exp_div: 4'd1,  exp_locked: 1'b1, exp_err: 1'b0};

        // Reset and the automatic initial sequence with div_cout toggling every 3 cycles.
        cmode = 3; ccnt = 0;
        tick(); tick();
        rst_hi_cnt = 0; done_cnt = 0;
        tick();
        chk("reset_state", {22'd0, div_reset, req_ready, busy, locked, done, lock_err, div_value},
            {22'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1});
        reset = 1'b0;
        run_until_idle(200, "init_seq");
        chk("init_hold_cycles", rst_hi_cnt, RESET_HOLD);
        chk("init_done_pulses", done_cnt, 1);
        chk("init_locked", locked, 1);
        chk("init_div_value", div_value, 1);
        chk("init_ready", req_ready, 1);

        // Table of requests.
        for (int i = 0; i < 6; i++) begin
            cmode = vecs[i].cout_per; ccnt = 0;
            rst_hi_cnt = 0; done_cnt = 0;
            req_valid = 1'b1; req_div = vecs[i].req_div;
            tick();
            req_valid = 1'b0;
            chk($sformatf("vec%0d_div_at_accept", i), div_value, vecs[i].exp_div);
            chk($sformatf("vec%0d_hold_at_accept", i), div_reset, 1);
            run_until_idle(200, $sformatf("vec%0d_seq", i));
            chk($sformatf("vec%0d_div_value", i), div_value, vecs[i].exp_div);
            chk($sformatf("vec%0d_locked", i), locked, vecs[i].exp_locked);
            chk($sformatf("vec%0d_lock_err", i), lock_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_hold_cycles", i), rst_hi_cnt, RESET_HOLD);
            chk($sformatf("vec%0d_done_pulses", i), done_cnt, {31'd0, vecs[i].exp_locked});
        end

        // Request held while busy; value changes after done and is latched at acceptance.
        cmode = 3; ccnt = 0;
        req_valid = 1'b1; req_div = 4'd7;
        tick();
        ready_cnt = 0;
        k = 0;
        while (m_ph != P_DONE && k < 200) begin tick(); k++; end
        chk("stall_reached_done", done, 1);
        chk("stall_no_ready_while_busy", ready_cnt, 0);
        chk("stall_div_kept", div_value, 7);
        req_div = 4'd9;
        tick();
        tick();
        req_valid = 1'b0;
        chk("stall_latched_value", div_value, 9);
        chk("stall_hold_entered", div_reset, 1);
        run_until_idle(200, "stall_seq");

        // Reset in WAIT_LOCK after one counted edge restarts the initial sequence.
        cmode = 3; ccnt = 0;
        req_valid = 1'b1; req_div = 4'd6;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!(m_ph == P_WAIT && m_ecnt == 1) && k < 100) begin tick(); k++; end
        checks++;
        if (!(m_ph == P_WAIT && m_ecnt == 1)) begin
            errors++;
            $display("FAIL midwait_reach: one-edge point not reached within 100 cycles");
        end
        rst_hi_cnt = 0; done_cnt = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midwait_reset_outputs", {22'd0, div_reset, req_ready, busy, locked, done, lock_err, div_value},
            {22'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1});
        run_until_idle(200, "midwait_restart");
        chk("midwait_hold_cycles", rst_hi_cnt, RESET_HOLD);
        chk("midwait_done_pulses", done_cnt, 1);

        // Random stimulus against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                k = int'($urandom_range(0, 7));
                cmode = (k == 7) ? -1 : k;
                ccnt = 0;
            end
            reset = ($urandom_range(0, 199) == 0);
            if (!req_valid && $urandom_range(0, 3) == 0) begin
                req_valid = 1'b1;
                req_div = 4'($urandom_range(0, 15));
            end
            tick();
            if (m_acc) begin
                if ($urandom_range(0, 2) == 0) req_div = 4'($urandom_range(0, 15));
                else req_valid = 1'b0;
            end
        end
        reset = 1'b0; req_valid = 1'b0; cmode = 3; ccnt = 0;
        run_until_idle(200, "random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
